// File: rtl/cpu_halt_ctrl.sv
// Run-control for the HALT instruction: freeze fetch, drain the pipeline,
// optionally stream data memory over a valid/ready port, then hold a sticky halt.
module cpu_halt_ctrl #(
   parameter int PIPE_DEPTH = 5,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int DUMP_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_req,
   input  logic              pipe_stall,
   input  logic              print_en,
   output logic              stall_fetch,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   input  logic              dump_ready,
   output logic              busy,
   output logic              halt
);

   localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PIPE_DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DUMP_WORDS - 1);

   typedef enum logic [2:0] {
      S_RUN,
      S_DRAIN,
      S_DUMP_RD,
      S_DUMP_OUT,
      S_HALTED
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] dump_addr_q;
   logic [DATA_W-1:0] data_q;
   logic              first_q;
   logic              handshake;

   assign handshake = (state_q == S_DUMP_OUT) && dump_ready;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      case (state_q)
         S_RUN: begin
            if (halt_req) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            if (!pipe_stall) begin
               if (cnt_q == CNT_LAST) begin
                  if (print_en) begin
                     state_d = S_DUMP_RD;
                     addr_d  = '0;
                  end else begin
                     state_d = S_HALTED;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DUMP_RD: state_d = S_DUMP_OUT;
         S_DUMP_OUT: begin
            if (handshake) begin
               if (addr_q == ADDR_LAST) begin
                  state_d = S_HALTED;
               end else begin
                  state_d = S_DUMP_RD;
                  addr_d  = addr_q + ADDR_W'(1);
               end
            end
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RUN;
         cnt_q       <= '0;
         addr_q      <= '0;
         dump_addr_q <= '0;
         data_q      <= '0;
         first_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         first_q <= (state_q == S_DUMP_RD);
         if (state_q == S_DUMP_RD) dump_addr_q <= addr_q;
         if (first_q)              data_q      <= mem_rd_data;
      end
   end

   // Read data arrives during the first DUMP_OUT cycle; it is passed straight
   // through then and held from the register until the consumer accepts it.
   assign dump_data   = first_q ? mem_rd_data : data_q;
   assign dump_addr   = dump_addr_q;
   assign dump_valid  = (state_q == S_DUMP_OUT);
   assign mem_rd_en   = (state_q == S_DUMP_RD);
   assign mem_rd_addr = addr_q;
   assign stall_fetch = (state_q != S_RUN);
   assign busy        = (state_q == S_DRAIN) || (state_q == S_DUMP_RD) || (state_q == S_DUMP_OUT);
   assign halt        = (state_q == S_HALTED);

endmodule

// File: tb/tb_cpu_halt_ctrl.sv
// Self-checking bench for cpu_halt_ctrl: drain timing, dump scoreboard,
// backpressure, asynchronous reset mid-dump and the all-ones address boundary.
module tb_cpu_halt_ctrl;

   localparam int PIPE_DEPTH = 5;
   localparam int ADDR_W     = 2;
   localparam int DATA_W     = 16;
   localparam int DUMP_WORDS = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              halt_req = 1'b0;
   logic              pipe_stall = 1'b0;
   logic              print_en = 1'b0;
   logic              stall_fetch;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data = '0;
   logic              dump_valid;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              dump_ready = 1'b0;
   logic              busy;
   logic              halt;

   logic [DATA_W-1:0] mem [DUMP_WORDS];
   exp_t              exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int rd_cnt = 0;
   int busy_cnt = 0;
   int hs_cnt = 0;
   int last_hs_cyc = 0;
   int viol = 0;
   bit chk_gap = 1'b0;

   cpu_halt_ctrl #(
      .PIPE_DEPTH(PIPE_DEPTH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .DUMP_WORDS(DUMP_WORDS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .halt_req   (halt_req),
      .pipe_stall (pipe_stall),
      .print_en   (print_en),
      .stall_fetch(stall_fetch),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_ready (dump_ready),
      .busy       (busy),
      .halt       (halt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous memory: data valid the cycle after the read strobe.
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: scoreboard pops on each handshake, plus invariant tracking.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd_en) rd_cnt++;
         if (busy) busy_cnt++;
         if (mem_rd_en && dump_valid) viol++;
         if (halt && (busy || mem_rd_en || dump_valid || !stall_fetch)) viol++;
         if (dump_valid && dump_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               check("hs_unexpected", 32'(dump_addr), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("dump_addr", 32'(dump_addr), 32'(e.addr));
               check("dump_data", 32'(dump_data), 32'(e.data));
            end
            if (chk_gap && hs_cnt > 1) check("hs_gap", 32'(cyc - last_hs_cyc), 32'd2);
            last_hs_cyc = cyc;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_stall_fetch"}, 32'(stall_fetch), 32'd0);
      check({tag, "_mem_rd_en"},   32'(mem_rd_en),   32'd0);
      check({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
      check({tag, "_dump_valid"},  32'(dump_valid),  32'd0);
      check({tag, "_dump_addr"},   32'(dump_addr),   32'd0);
      check({tag, "_dump_data"},   32'(dump_data),   32'd0);
      check({tag, "_busy"},        32'(busy),        32'd0);
      check({tag, "_halt"},        32'(halt),        32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      halt_req = 1'b0;
      pipe_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rd_cnt = 0;
      busy_cnt = 0;
      hs_cnt = 0;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.addr = ADDR_W'(i);
         e.data = mem[i];
         exp_q.push_back(e);
      end
   endtask

   // Drives a one-cycle halt_req; t0 = edge count at the sampling edge.
   task automatic pulse_halt();
      @(posedge clk);
      #1 halt_req = 1'b1;
      check("stall_before_halt", 32'(stall_fetch), 32'd0);
      @(posedge clk);
      #1 halt_req = 1'b0;
      t0 = cyc;
      check("stall_after_halt", 32'(stall_fetch), 32'd1);
      check("busy_after_halt", 32'(busy), 32'd1);
   endtask

   task automatic wait_halt(input string tag, output int lat);
      bit seen = 1'b0;
      lat = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (halt) begin
            seen = 1'b1;
            lat = cyc - t0 + 1;
         end
      end
      if (!seen) check({tag, "_halt_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int lat;
      int held;
      int hcnt;
      mem[0] = 16'h1111;
      mem[1] = 16'h2222;
      mem[2] = 16'h3333;
      mem[3] = 16'h4444;

      #2 check_all_zero("reset");
      do_reset();

      // Drain only
      print_en = 1'b0;
      pulse_halt();
      wait_halt("drain", lat);
      check("drain_latency", 32'(lat), 32'(PIPE_DEPTH + 1));
      check("drain_busy_cycles", 32'(busy_cnt), 32'(PIPE_DEPTH));
      check("drain_no_rd", 32'(rd_cnt), 32'd0);
      check("drain_stall_fetch", 32'(stall_fetch), 32'd1);

      // Stalled drain with a stray halt_req during DRAIN
      do_reset();
      pulse_halt();
      @(posedge clk);
      #1 pipe_stall = 1'b1;
      halt_req = 1'b1;
      @(posedge clk);
      #1 halt_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 pipe_stall = 1'b0;
      wait_halt("stalled", lat);
      check("stalled_latency", 32'(lat), 32'(PIPE_DEPTH + 4));
      check("stalled_busy_cycles", 32'(busy_cnt), 32'(PIPE_DEPTH + 3));

      // Full dump at full rate
      do_reset();
      print_en = 1'b1;
      dump_ready = 1'b1;
      chk_gap = 1'b1;
      push_words(DUMP_WORDS);
      pulse_halt();
      wait_halt("full", lat);
      check("full_halt_after_last_hs", 32'(cyc - last_hs_cyc), 32'd1);
      check("full_hs_count", 32'(hs_cnt), 32'(DUMP_WORDS));
      check("full_rd_count", 32'(rd_cnt), 32'(DUMP_WORDS));
      check("full_queue_empty", 32'(exp_q.size()), 32'd0);
      chk_gap = 1'b0;

      // Backpressure on word 2
      do_reset();
      push_words(DUMP_WORDS);
      pulse_halt();
      held = 0;
      for (int i = 0; i < 200 && !halt; i++) begin
         @(posedge clk);
         #1;
         if (dump_valid && dump_addr == 2'd2 && held < 7) begin
            if (held > 0) begin
               check("bp_valid", 32'(dump_valid), 32'd1);
               check("bp_data", 32'(dump_data), 32'h3333);
            end
            dump_ready = 1'b0;
            held++;
         end else begin
            dump_ready = 1'b1;
         end
      end
      check("bp_held_cycles", 32'(held), 32'd7);
      check("bp_halt", 32'(halt), 32'd1);
      check("bp_hs_count", 32'(hs_cnt), 32'(DUMP_WORDS));
      check("bp_rd_count", 32'(rd_cnt), 32'(DUMP_WORDS));
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-dump while word 1 is presented
      do_reset();
      dump_ready = 1'b1;
      push_words(1);
      pulse_halt();
      held = 0;
      for (int i = 0; i < 100 && held == 0; i++) begin
         @(posedge clk);
         #1;
         if (dump_valid && dump_addr == 2'd1) begin
            dump_ready = 1'b0;
            held = 1;
         end
      end
      check("mid_reached_addr1", 32'(held), 32'd1);
      #1 rst = 1'b1;
      #1 check_all_zero("mid_reset");
      check("mid_queue_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      rd_cnt = 0;
      hs_cnt = 0;
      dump_ready = 1'b1;
      push_words(DUMP_WORDS);
      pulse_halt();
      wait_halt("restart", lat);
      check("restart_hs_count", 32'(hs_cnt), 32'(DUMP_WORDS));
      check("restart_last_addr", 32'(dump_addr), 32'(DUMP_WORDS - 1));
      check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

      // Sticky halt with random halt_req / dump_ready
      hcnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1 halt_req = 1'($urandom_range(0, 1));
         dump_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (halt) hcnt++;
      end
      halt_req = 1'b0;
      check("sticky_halt_cycles", 32'(hcnt), 32'd100);
      check("sticky_no_extra_rd", 32'(rd_cnt), 32'(DUMP_WORDS));
      check("invariant_violations", 32'(viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cpu_halt_ctrl.md
Name: cpu_halt_ctrl

Overview:
- Run-control block inside CpuTop that produces the `halt` and end-of-run memory-trace behaviour a bench observes from outside.
- On a decoded HALT instruction it freezes fetch and lets the pipeline drain. It then optionally walks data memory, streaming each word over a valid/ready dump port. Finally it raises a sticky `halt`.

Parameters:
- PIPE_DEPTH, 5, number of non-stalled cycles needed to retire everything behind HALT.
- ADDR_W, 8, data-memory address width.
- DATA_W, 16, data-memory word width.
- DUMP_WORDS, 256, words dumped from address 0; range 1..2^ADDR_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- halt_req  in  1  single-cycle pulse from decode when the HALT opcode is decoded.
- pipe_stall  in  1  pipeline hazard stall; drain counter does not advance while high.
- print_en  in  1  enables the memory dump; sampled on the last DRAIN cycle.
- stall_fetch  out  1  holds the PC and injects bubbles from halt_req onward.
- mem_rd_en  out  1  data-memory read strobe.
- mem_rd_addr  out  ADDR_W  data-memory read address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- dump_valid  out  1  dump word available.
- dump_addr  out  ADDR_W  address of the dump word.
- dump_data  out  DATA_W  dump word.
- dump_ready  in  1  consumer accepts the word on a cycle where dump_valid && dump_ready.
- busy  out  1  high in DRAIN, DUMP_RD, DUMP_OUT.
- halt  out  1  sticky CPU-halted indication.

Behaviour:
- Reset (async, rst=1): state=RUN. All outputs are 0: stall_fetch, mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data, busy, halt. Drain counter=0, address counter=0. Reset asserted in any state, including mid-dump, aborts immediately; no partial handshake completes.
- RUN:
  - On halt_req=1 → DRAIN with drain counter=0.
  - stall_fetch is a registered output, high from the cycle after halt_req.
  - halt_req is ignored in every state other than RUN.
- DRAIN:
  - The counter increments on each cycle with pipe_stall=0.
  - When the counter is at PIPE_DEPTH-1 and pipe_stall=0: if print_en=1 → DUMP_RD with address=0; else → HALTED.
  - halt_req and pipe_stall together in RUN still enter DRAIN; the stall only delays counting.
- DUMP_RD (1 cycle):
  - mem_rd_en=1, mem_rd_addr=address.
  - → DUMP_OUT.
- DUMP_OUT:
  - On entry, mem_rd_data is registered into dump_data, and dump_addr=address.
  - dump_valid=1; data and address are held stable until accepted.
  - On handshake: if address==DUMP_WORDS-1 → HALTED; else address+1 → DUMP_RD.
  - dump_valid is deasserted the cycle after the handshake.
- Throughput and latency:
  - With dump_ready tied high, one word completes every 2 cycles.
  - The address counter never wraps; DUMP_WORDS=2^ADDR_W ends at the all-ones address.
- HALTED:
  - halt=1, stall_fetch=1, busy=0; there is no exit except reset.
  - Minimum latency from the halt_req cycle to halt=1 with print_en=0 and no stalls is PIPE_DEPTH+1 rising edges.
- mem_rd_en is never high outside DUMP_RD. dump_valid is never high outside DUMP_OUT.

Test Plan:
- Drain only:
  - Stimulus: PIPE_DEPTH=5, pipe_stall=0, print_en=0, halt_req pulse at edge N.
  - Required: stall_fetch=1 from N+1, busy=1 for 5 cycles, halt=1 at N+6, no mem_rd_en ever.
- Stalled drain:
  - Stimulus: same as drain only, with pipe_stall high for 3 cycles inside DRAIN.
  - Required: halt rises at N+9; a second halt_req during DRAIN has no effect.
- Full dump at full rate:
  - Stimulus: DUMP_WORDS=4, memory preloaded with words 0x1111/0x2222/0x3333/0x4444, dump_ready=1, print_en=1.
  - Required: exactly 4 handshakes with addr 0..3 carrying those values, 2 cycles apart; halt=1 one cycle after the last handshake.
- Backpressure:
  - Stimulus: dump_ready low for 7 cycles on word 2.
  - Required: dump_valid, dump_addr=2 and dump_data=0x3333 stay stable throughout; no extra mem_rd_en; no word lost or duplicated.
- Reset mid-dump:
  - Stimulus: assert rst while dump_addr=1.
  - Required: all outputs are 0 asynchronously (before the next edge).
  - Required: after release, a fresh halt_req restarts the dump from addr 0.
- Boundary:
  - Stimulus: ADDR_W=2, DUMP_WORDS=4.
  - Required: the last word is addr 3 with no wrap to 0; HALTED is reached.
  - Required: halt stays 1 for 100 further cycles regardless of halt_req or dump_ready.
